instr_fetch: RTL and testbench

Instruction fetch sequencer upstream of the decoder. It holds the program counter and reads 16-bit instruction words from a synchronous instruction ROM. Each word is presented to the decoder on `instruction` with the `IR` strobe, and the block waits for the execution FSMs (MOV/ALU/LDSR) to return `IF` before fetching the next word. It also handles branch-target loading and a HALT opcode.

---
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch sequencer sitting in front of the decoder. Holds the
// program counter, reads one 16-bit word per instruction from a synchronous
// ROM, presents it on `instruction` with the IR strobe, and waits for the
// execution FSMs to return IF before fetching the next word. Supports branch
// target loading (pc_load/pc_in, qualified by IF) and a HALT opcode that stops
// fetching until reset.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   run          fetch enable (sampled in IDLE and at instruction completion)
//   mem_addr     ROM address, always equal to pc
//   mem_rd       ROM read strobe, one cycle per fetch
//   mem_data     ROM read data, valid the cycle after mem_rd
//   instruction  latched instruction word {opcode, i, j}
//   IR           instruction-ready level to the decoder
//   IF           instruction-finished from the execution FSMs
//   pc_load      branch request (only acted on together with IF)
//   pc_in        branch target
//   pc           current program counter
//   halted       HALT opcode fetched, fetching stopped
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OP  = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_data,
   output logic [15:0]       instruction,
   output logic              IR,
   input  logic              IF,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_ISSUE,
      S_HALT
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [15:0]       instr_q;
   logic              mem_rd_q;
   logic              ir_q;
   logic              halted_q;

   // Program counter value to take at instruction completion. The plain
   // increment is ADDR_W wide, so the top address wraps to zero.
   logic [ADDR_W-1:0] pc_next_d;
   assign pc_next_d = pc_load ? pc_in : pc_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= 16'h0000;
         mem_rd_q <= 1'b0;
         ir_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (run) begin
                  state_q  <= S_REQ;
                  mem_rd_q <= 1'b1;
               end
            end
            S_REQ: begin
               state_q  <= S_WAIT;
               mem_rd_q <= 1'b0;
            end
            S_WAIT: begin
               instr_q <= mem_data;
               // A HALT word is latched but never issued to the decoder.
               if (mem_data[15:12] == HALT_OP) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state_q <= S_ISSUE;
                  ir_q    <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (IF) begin
                  pc_q     <= pc_next_d;
                  ir_q     <= 1'b0;
                  mem_rd_q <= run;
                  state_q  <= run ? S_REQ : S_IDLE;
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q  <= S_IDLE;
               mem_rd_q <= 1'b0;
               ir_q     <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr    = pc_q;
   assign pc          = pc_q;
   assign mem_rd      = mem_rd_q;
   assign instruction = instr_q;
   assign IR          = ir_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch: synchronous ROM model, a tiny MOV-style
// execution model (opcode 9: R[i] <= j, opcode 10: R[i] <= R[j]) and
// hand-computed expected values. Inputs driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_data;
   logic [15:0] instruction;
   logic        IR;
   logic        IF;
   logic        pc_load;
   logic [7:0]  pc_in;
   logic [7:0]  pc;
   logic        halted;

   logic [15:0] rom  [256];
   logic [15:0] regs [64];

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int rd_snap;

   always #5 clk = ~clk;

   instr_fetch #(
      .ADDR_W  (8),
      .RESET_PC(8'h00),
      .HALT_OP (4'hF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .instruction(instruction),
      .IR         (IR),
      .IF         (IF),
      .pc_load    (pc_load),
      .pc_in      (pc_in),
      .pc         (pc),
      .halted     (halted)
   );

   // Synchronous ROM plus a count of read strobes.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_data <= rom[mem_addr];
         rd_cnt   <= rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_ir(input string tag);
      int n = 0;
      while (!IR && n < 10) begin
         tick();
         n++;
      end
      check({tag, " IR rise"}, 32'(IR), 32'd1);
   endtask

   task automatic execute();
      logic [3:0] op;
      logic [5:0] i;
      logic [5:0] j;
      op = instruction[15:12];
      i  = instruction[11:6];
      j  = instruction[5:0];
      if (op == 4'd9)  regs[i] = {10'd0, j};
      if (op == 4'd10) regs[i] = regs[j];
   endtask

   task automatic complete(input logic ld, input logic [7:0] tgt);
      pc_load = ld;
      pc_in   = tgt;
      IF      = 1'b1;
      tick();
      IF      = 1'b0;
      pc_load = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) rom[k] = 16'h0000;
      for (int k = 0; k < 64; k++)  regs[k] = 16'h0000;
      rom[0]     = 16'h9084;   // {9, 2, 4}
      rom[1]     = 16'hA002;   // {10, 0, 2}
      rom[2]     = 16'hF000;   // HALT
      rom[8'h20] = 16'h1234;
      rom[8'hFF] = 16'h2222;
      mem_data   = 16'h0000;

      reset = 1'b1; run = 1'b0; IF = 1'b0; pc_load = 1'b0; pc_in = 8'h00;
      repeat (3) tick();
      check("rst pc", 32'(pc), 32'h0);
      check("rst instruction", 32'(instruction), 32'h0);
      check("rst IR", 32'(IR), 32'd0);
      check("rst mem_rd", 32'(mem_rd), 32'd0);
      check("rst halted", 32'(halted), 32'd0);

      // First fetch: E0 samples run, mem_rd in the next cycle, IR from E2.
      reset = 1'b0; run = 1'b1;
      tick();
      check("fetch0 mem_rd", 32'(mem_rd), 32'd1);
      check("fetch0 mem_addr", 32'(mem_addr), 32'h0);
      tick();
      check("wait0 IR", 32'(IR), 32'd0);
      check("wait0 mem_rd", 32'(mem_rd), 32'd0);
      tick();
      check("issue0 IR", 32'(IR), 32'd1);
      check("issue0 instruction", 32'(instruction), 32'h9084);
      repeat (2) tick();
      check("issue0 IR held", 32'(IR), 32'd1);
      check("issue0 pc held", 32'(pc), 32'h0);
      execute();
      complete(1'b0, 8'h00);
      check("done0 pc", 32'(pc), 32'h1);
      check("done0 IR", 32'(IR), 32'd0);
      check("done0 mem_rd", 32'(mem_rd), 32'd1);
      check("done0 mem_addr", 32'(mem_addr), 32'h1);
      tick();
      check("wait1 IR", 32'(IR), 32'd0);
      tick();
      check("issue1 IR", 32'(IR), 32'd1);
      check("issue1 instruction", 32'(instruction), 32'hA002);
      execute();
      check("R0 value", 32'(regs[0]), 32'd4);

      // pc_load without IF has no effect, then a real branch.
      pc_load = 1'b1; pc_in = 8'h20;
      tick();
      pc_load = 1'b0;
      check("load no IF pc", 32'(pc), 32'h1);
      check("load no IF IR", 32'(IR), 32'd1);
      complete(1'b1, 8'h20);
      check("branch mem_rd", 32'(mem_rd), 32'd1);
      check("branch mem_addr", 32'(mem_addr), 32'h20);
      wait_ir("branch");
      check("branch instruction", 32'(instruction), 32'h1234);

      // Wrap-around from 0xFF.
      complete(1'b1, 8'hFF);
      wait_ir("ff");
      check("ff instruction", 32'(instruction), 32'h2222);
      check("ff pc", 32'(pc), 32'hFF);
      complete(1'b0, 8'h00);
      check("wrap pc", 32'(pc), 32'h0);
      check("wrap mem_rd", 32'(mem_rd), 32'd1);
      check("wrap mem_addr", 32'(mem_addr), 32'h0);
      wait_ir("wrap");
      check("wrap instruction", 32'(instruction), 32'h9084);

      // HALT at address 2.
      complete(1'b1, 8'h02);
      tick();
      tick();
      check("halt halted", 32'(halted), 32'd1);
      check("halt IR", 32'(IR), 32'd0);
      check("halt pc", 32'(pc), 32'h2);
      check("halt instruction", 32'(instruction), 32'hF000);
      rd_snap = rd_cnt;
      for (int k = 0; k < 6; k++) begin
         run = ~run;
         tick();
         check("halt IR low", 32'(IR), 32'd0);
      end
      check("halt no mem_rd", 32'(rd_cnt), 32'(rd_snap));
      check("halt pc kept", 32'(pc), 32'h2);
      reset = 1'b1; run = 1'b0;
      tick();
      reset = 1'b0;
      check("unhalt halted", 32'(halted), 32'd0);
      check("unhalt pc", 32'(pc), 32'h0);

      // Reset arriving together with IF in ISSUE.
      run = 1'b1;
      wait_ir("mid");
      reset = 1'b1; IF = 1'b1; run = 1'b0;
      tick();
      reset = 1'b0; IF = 1'b0;
      check("midrst IR", 32'(IR), 32'd0);
      check("midrst pc", 32'(pc), 32'h0);
      check("midrst mem_rd", 32'(mem_rd), 32'd0);

      // run dropped during ISSUE; IF in the first ISSUE cycle.
      run = 1'b1;
      wait_ir("drop");
      check("drop instruction", 32'(instruction), 32'h9084);
      run = 1'b0;
      IF  = 1'b1;
      tick();
      IF  = 1'b0;
      check("drop IR", 32'(IR), 32'd0);
      check("drop pc", 32'(pc), 32'h1);
      check("drop mem_rd", 32'(mem_rd), 32'd0);
      rd_snap = rd_cnt;
      repeat (4) tick();
      check("idle no mem_rd", 32'(rd_cnt), 32'(rd_snap));
      check("idle IR", 32'(IR), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
